// File: rtl/anffl_tex_pkg.sv
// Shared definitions for the texel fetch stage: format codes, format-class
// decode, FSM state encoding and the bit-replication expansion helpers.
package anffl_tex_pkg;

  // 5-bit texture format codes (linear / tiled variants share an unpack)
  localparam logic [4:0] FMT_RGB24_L    = 5'b00000;
  localparam logic [4:0] FMT_RGB24_T    = 5'b00011;
  localparam logic [4:0] FMT_RGBA32_L   = 5'b00100;
  localparam logic [4:0] FMT_RGBA32_T   = 5'b00111;
  localparam logic [4:0] FMT_RGB565_L   = 5'b00001;
  localparam logic [4:0] FMT_RGB565_T   = 5'b01011;
  localparam logic [4:0] FMT_RGBA4444_L = 5'b00101;
  localparam logic [4:0] FMT_RGBA4444_T = 5'b01111;
  localparam logic [4:0] FMT_RGB555     = 5'b01001;
  localparam logic [4:0] FMT_RGBA5551   = 5'b01101;
  localparam logic [4:0] FMT_R8         = 5'b10011;
  localparam logic [4:0] FMT_R16        = 5'b10111;

  // Format class lives in the two low code bits; block-compressed is not handled here
  localparam logic [1:0] CLS_COMPRESSED = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_OUT
  } state_e;

  function automatic logic [1:0] fmt_class(input logic [4:0] fmt);
    return fmt[1:0];
  endfunction

  // Only 24bpp texels can straddle a word boundary
  function automatic logic is_rgb24(input logic [4:0] fmt);
    return (fmt == FMT_RGB24_L) || (fmt == FMT_RGB24_T);
  endfunction

  function automatic logic [7:0] exp5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] exp6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

  function automatic logic [7:0] exp4(input logic [3:0] v);
    return {v, v};
  endfunction

endpackage

// File: rtl/anffl_tex_unpack.sv
// Combinational texel unpack: picks the texel bytes out of a two-word window
// and expands them to RGBA8888 ({A,B,G,R}); unsupported formats flag o_err
// and return zero data.
module anffl_tex_unpack
  import anffl_tex_pkg::*;
(
  input  logic [63:0] i_win,
  input  logic [1:0]  i_off,
  input  logic [4:0]  i_fmt,
  output logic [31:0] o_data,
  output logic        o_err
);

  logic [23:0] w_sel;
  logic [15:0] w_v16;

  // Byte-aligned view for 8/24bpp, half-word view for 16bpp (address bit 0 ignored)
  assign w_sel = 24'(i_win >> {i_off, 3'b000});
  assign w_v16 = i_win[{i_off[1], 4'b0000} +: 16];

  // Format decode and channel expansion
  always_comb begin
    // NOTE: outputs get defaults first so every path assigns them and no latch is inferred.
    o_data = 32'h0;
    o_err  = 1'b0;
    if (fmt_class(i_fmt) == CLS_COMPRESSED) begin
      o_err = 1'b1;
    end else begin
      case (i_fmt)
        FMT_RGB24_L, FMT_RGB24_T:
          o_data = {8'hFF, w_sel[23:16], w_sel[15:8], w_sel[7:0]};
        FMT_RGBA32_L, FMT_RGBA32_T:
          o_data = i_win[31:0];
        FMT_RGB565_L, FMT_RGB565_T:
          o_data = {8'hFF, exp5(w_v16[4:0]), exp6(w_v16[10:5]), exp5(w_v16[15:11])};
        FMT_RGBA4444_L, FMT_RGBA4444_T:
          o_data = {exp4(w_v16[3:0]), exp4(w_v16[7:4]), exp4(w_v16[11:8]), exp4(w_v16[15:12])};
        FMT_RGB555:
          o_data = {8'hFF, exp5(w_v16[4:0]), exp5(w_v16[9:5]), exp5(w_v16[14:10])};
        FMT_RGBA5551:
          o_data = {(w_v16[0] ? 8'hFF : 8'h00), exp5(w_v16[5:1]), exp5(w_v16[10:6]),
                    exp5(w_v16[15:11])};
        FMT_R8:
          o_data = {8'hFF, 16'h0, w_sel[7:0]};
        FMT_R16:
          o_data = {8'hFF, 16'h0, w_v16[15:8]};
        default:
          o_err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/anffl_tex_fetch.sv
// Texel fetch stage: accepts one texel address + format, reads one or two
// 32-bit words, unpacks to RGBA8888 and returns it with the request tag.
// Optional feature: define ANFFL_TEX_FETCH_LASTWORD_CACHE_EN to enable a
// one-entry cache of the last memory response that can skip word reads.
module anffl_tex_fetch
  import anffl_tex_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [31:0]      reqAddr,
  input  logic [4:0]       reqFormat,
  input  logic [TAG_W-1:0] reqTag,
  output logic             memReqValid,
  input  logic             memReqReady,
  output logic [31:0]      memAddr,
  input  logic             memRspValid,
  input  logic [31:0]      memRspData,
  input  logic             cacheInv,
  output logic             texValid,
  input  logic             texReady,
  output logic [31:0]      texData,
  output logic [TAG_W-1:0] texTag,
  output logic             texErr
);

  state_e           r_state, w_next;
  logic [29:0]      r_mem_addr;
  logic [1:0]       r_off;
  logic [4:0]       r_fmt;
  logic [TAG_W-1:0] r_tag;
  logic             r_need2, r_w1_hit;
  logic [31:0]      r_w0, r_w1;
  logic [31:0]      r_tex_data;
  logic [TAG_W-1:0] r_tex_tag;
  logic             r_tex_err;

  logic        w_idle, w_accept, w_need2, w_rsp;
  logic [29:0] w_word0;
  logic        w_hit0, w_hit1;
  logic [31:0] w_c_data;
  logic [4:0]  w_u_fmt;
  logic [1:0]  w_u_off;
  logic [31:0] w_u_w0, w_u_w1, w_u_data;
  logic        w_u_err;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && reqValid;
  assign w_need2  = is_rgb24(reqFormat) && reqAddr[1];
  assign w_word0  = reqAddr[31:2];
  assign w_rsp    = memRspValid && ((r_state == ST_WAIT0) || (r_state == ST_WAIT1));

`ifdef ANFFL_TEX_FETCH_LASTWORD_CACHE_EN
  logic        r_c_valid;
  logic [29:0] r_c_addr;
  logic [31:0] r_c_data;

  // An invalidate in the accept cycle forces a miss
  assign w_c_data = r_c_data;
  assign w_hit0   = r_c_valid && !cacheInv && (r_c_addr == w_word0);
  assign w_hit1   = r_c_valid && !cacheInv && w_need2 && (r_c_addr == w_word0 + 30'd1);

  // Cache valid: set by any response, cleared by invalidate (invalidate wins)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c_valid <= 1'b0;
    end else begin
      if (w_rsp)    r_c_valid <= 1'b1;
      if (cacheInv) r_c_valid <= 1'b0;
    end
  end

  // Cache tag/data capture of the last response
  // NOTE: tag and data have no reset; they are never used while r_c_valid is low.
  always_ff @(posedge clk) begin
    if (w_rsp) begin
      r_c_addr <= r_mem_addr;
      r_c_data <= memRspData;
    end
  end
`else
  logic w_unused_inv;

  assign w_c_data     = 32'h0;
  assign w_hit0       = 1'b0;
  assign w_hit1       = 1'b0;
  assign w_unused_inv = cacheInv;
`endif

  // Unpack sees the request directly in IDLE (cache hit / error) and the
  // arriving response word in WAITx so results register on the same edge
  assign w_u_fmt = w_idle ? reqFormat : r_fmt;
  assign w_u_off = w_idle ? reqAddr[1:0] : r_off;
  assign w_u_w0  = w_idle ? w_c_data : ((r_state == ST_WAIT0) ? memRspData : r_w0);
  assign w_u_w1  = (r_state == ST_WAIT1) ? memRspData : r_w1;

  anffl_tex_unpack u_unpack (
    .i_win  ({w_u_w1, w_u_w0}),
    .i_off  (w_u_off),
    .i_fmt  (w_u_fmt),
    .o_data (w_u_data),
    .o_err  (w_u_err)
  );

  // Next-state logic of the fetch sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (reqValid) begin
          if (w_u_err)     w_next = ST_OUT;
          else if (w_hit0) w_next = w_need2 ? ST_REQ1 : ST_OUT;
          else             w_next = ST_REQ0;
        end
      end
      ST_REQ0:  if (memReqReady) w_next = ST_WAIT0;
      ST_WAIT0: if (memRspValid) w_next = (r_need2 && !r_w1_hit) ? ST_REQ1 : ST_OUT;
      ST_REQ1:  if (memReqReady) w_next = ST_WAIT1;
      ST_WAIT1: if (memRspValid) w_next = ST_OUT;
      ST_OUT:   if (texReady)    w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State, request context, captured words and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mem_addr <= '0;
      r_off      <= '0;
      r_fmt      <= '0;
      r_tag      <= '0;
      r_need2    <= 1'b0;
      r_w1_hit   <= 1'b0;
      r_w0       <= '0;
      r_w1       <= '0;
      r_tex_data <= '0;
      r_tex_tag  <= '0;
      r_tex_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      r_state <= w_next;
      if (w_accept) begin
        r_off      <= reqAddr[1:0];
        r_fmt      <= reqFormat;
        r_tag      <= reqTag;
        r_need2    <= w_need2;
        r_w1_hit   <= w_hit1;
        r_w0       <= w_c_data;
        r_w1       <= w_c_data;
        r_mem_addr <= w_hit0 ? (w_word0 + 30'd1) : w_word0;
      end
      if ((r_state == ST_WAIT0) && memRspValid) begin
        r_w0       <= memRspData;
        r_mem_addr <= r_mem_addr + 30'd1;
      end
      if ((r_state == ST_WAIT1) && memRspValid) r_w1 <= memRspData;
      if ((w_next == ST_OUT) && (r_state != ST_OUT)) begin
        r_tex_data <= w_u_data;
        r_tex_err  <= w_u_err;
        r_tex_tag  <= w_idle ? reqTag : r_tag;
      end
    end
  end

  assign reqReady    = rst_n && w_idle;
  assign memReqValid = (r_state == ST_REQ0) || (r_state == ST_REQ1);
  assign memAddr     = {r_mem_addr, 2'b00};
  assign texValid    = (r_state == ST_OUT);
  assign texData     = r_tex_data;
  assign texTag      = r_tex_tag;
  assign texErr      = r_tex_err;

endmodule

// File: tb/tb_anffl_tex_fetch.sv
// Directed self-checking bench for anffl_tex_fetch. Inputs are driven and
// outputs sampled on the falling clock edge; the bench plays the memory.
module tb_anffl_tex_fetch;

`ifdef ANFFL_TEX_FETCH_LASTWORD_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqReady;
  logic [31:0] reqAddr;
  logic [4:0]  reqFormat;
  logic [7:0]  reqTag;
  logic        memReqValid, memReqReady;
  logic [31:0] memAddr;
  logic        memRspValid;
  logic [31:0] memRspData;
  logic        cacheInv;
  logic        texValid, texReady;
  logic [31:0] texData;
  logic [7:0]  texTag;
  logic        texErr;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  anffl_tex_fetch #(.TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
    .reqFormat(reqFormat), .reqTag(reqTag),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memAddr(memAddr),
    .memRspValid(memRspValid), .memRspData(memRspData),
    .cacheInv(cacheInv),
    .texValid(texValid), .texReady(texReady), .texData(texData),
    .texTag(texTag), .texErr(texErr)
  );

  // Observations of the last do_fetch transaction
  int          o_nreq, o_acc_cyc, o_first_req_cyc, o_rsp_cyc, o_tv_cyc;
  logic [31:0] o_addr [4];
  logic [31:0] o_data;
  logic [7:0]  o_tag;
  logic        o_err, o_hold_ok, o_idle_ok, o_addr_stable, o_timeout;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  fmt;
    logic [31:0] word;
    logic [31:0] exp;
  } vec_t;

  // One request, served by the bench memory with 'stall' not-ready cycles per word
  task automatic do_fetch(input logic [31:0] addr, input logic [4:0] fmt, input logic [7:0] tag,
                          input logic [31:0] d0, input logic [31:0] d1, input int stall,
                          input int hold, input logic inv_acc);
    int          stall_left;
    logic        rsp_pending, got, sa_valid;
    logic [31:0] sa;
    o_nreq = 0; o_first_req_cyc = -1; o_rsp_cyc = -1; o_tv_cyc = -1;
    o_hold_ok = 1'b1; o_idle_ok = 1'b0; o_addr_stable = 1'b1; o_timeout = 1'b0;
    o_data = 'x; o_tag = 'x; o_err = 1'bx;
    for (int k = 0; k < 4; k++) o_addr[k] = 32'hx;
    stall_left = stall; rsp_pending = 1'b0; got = 1'b0; sa_valid = 1'b0; sa = '0;
    @(negedge clk);
    for (int g = 0; g < 20 && !reqReady; g++) @(negedge clk);
    if (!reqReady) begin o_timeout = 1'b1; return; end
    reqValid = 1'b1; reqAddr = addr; reqFormat = fmt; reqTag = tag; cacheInv = inv_acc;
    o_acc_cyc = cyc;
    @(negedge clk);
    reqValid = 1'b0; cacheInv = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (texValid) begin o_tv_cyc = cyc; got = 1'b1; break; end
      memRspValid = 1'b0;
      if (rsp_pending) begin
        memRspValid = 1'b1; memRspData = (o_nreq == 1) ? d0 : d1;
        o_rsp_cyc = cyc; rsp_pending = 1'b0;
      end
      if (memReqValid) begin
        if (o_first_req_cyc < 0) o_first_req_cyc = cyc;
        if (!sa_valid) begin sa = memAddr; sa_valid = 1'b1; end
        else if (memAddr !== sa) o_addr_stable = 1'b0;
        if (stall_left > 0) begin
          memReqReady = 1'b0; stall_left--;
        end else begin
          memReqReady = 1'b1;
          if (o_nreq < 4) o_addr[o_nreq] = memAddr;
          o_nreq++; rsp_pending = 1'b1; stall_left = stall; sa_valid = 1'b0;
        end
      end else begin
        memReqReady = 1'b0;
      end
      @(negedge clk);
    end
    memRspValid = 1'b0; memReqReady = 1'b0;
    if (!got) begin o_timeout = 1'b1; return; end
    o_data = texData; o_tag = texTag; o_err = texErr;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!texValid || texData !== o_data || texErr !== o_err || texTag !== o_tag) o_hold_ok = 1'b0;
    end
    texReady = 1'b1;
    @(negedge clk);
    texReady = 1'b0;
    o_idle_ok = !texValid && reqReady;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (reqReady !== 1'b0) $display("FAIL rst_reqReady: got %b want 0", reqReady); else n_pass++;
    n_checks++; if (memReqValid !== 1'b0) $display("FAIL rst_memReqValid: got %b want 0", memReqValid); else n_pass++;
    n_checks++; if (memAddr !== 32'h0) $display("FAIL rst_memAddr: got %h want 0", memAddr); else n_pass++;
    n_checks++; if (texValid !== 1'b0) $display("FAIL rst_texValid: got %b want 0", texValid); else n_pass++;
    n_checks++; if ({texData, texTag, texErr} !== 41'h0) $display("FAIL rst_texOut: got %h/%h/%b want 0", texData, texTag, texErr); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (reqReady !== 1'b1) $display("FAIL idle_reqReady: got %b want 1", reqReady); else n_pass++;
  endtask

  task automatic test_rgba32();
    do_fetch(32'h1000, 5'b00100, 8'h5A, 32'h44332211, 32'h0, 0, 0, 1'b0);
    n_checks++; if (o_timeout !== 1'b0) $display("FAIL rgba32_timeout: got %b want 0", o_timeout); else n_pass++;
    n_checks++; if (o_nreq != 1) $display("FAIL rgba32_nreq: got %0d want 1", o_nreq); else n_pass++;
    n_checks++; if (o_addr[0] !== 32'h1000) $display("FAIL rgba32_addr: got %h want 00001000", o_addr[0]); else n_pass++;
    n_checks++; if (o_data !== 32'h44332211) $display("FAIL rgba32_data: got %h want 44332211", o_data); else n_pass++;
    n_checks++; if (o_tag !== 8'h5A || o_err !== 1'b0) $display("FAIL rgba32_tag_err: got %h/%b want 5a/0", o_tag, o_err); else n_pass++;
    n_checks++; if (o_first_req_cyc != o_acc_cyc + 1) $display("FAIL rgba32_req_lat: got %0d want %0d", o_first_req_cyc, o_acc_cyc + 1); else n_pass++;
    n_checks++; if (o_tv_cyc != o_rsp_cyc + 1) $display("FAIL rgba32_tv_lat: got %0d want %0d", o_tv_cyc, o_rsp_cyc + 1); else n_pass++;
    n_checks++; if (o_idle_ok !== 1'b1) $display("FAIL rgba32_back_idle: got %b want 1", o_idle_ok); else n_pass++;
  endtask

  task automatic test_rgb24_straddle();
    do_fetch(32'h2002, 5'b00000, 8'h24, 32'hCCBBAA99, 32'h000000DD, 0, 0, 1'b0);
    n_checks++; if (o_nreq != 2) $display("FAIL rgb24_nreq: got %0d want 2", o_nreq); else n_pass++;
    n_checks++; if (o_addr[0] !== 32'h2000 || o_addr[1] !== 32'h2004) $display("FAIL rgb24_addrs: got %h,%h want 00002000,00002004", o_addr[0], o_addr[1]); else n_pass++;
    n_checks++; if (o_data !== 32'hFFDDCCBB) $display("FAIL rgb24_data: got %h want ffddccbb", o_data); else n_pass++;
    n_checks++; if (o_tv_cyc != o_rsp_cyc + 1) $display("FAIL rgb24_tv_lat: got %0d want %0d", o_tv_cyc, o_rsp_cyc + 1); else n_pass++;
  endtask

  task automatic test_formats();
    vec_t vecs [11];
    vecs[0]  = '{32'h3002, 5'b00001, 32'hF8000000, 32'hFF0000FF};
    vecs[1]  = '{32'h3104, 5'b01101, 32'h00000001, 32'hFF000000};
    vecs[2]  = '{32'h3208, 5'b01011, 32'h000007E0, 32'hFF00FF00};
    vecs[3]  = '{32'h330C, 5'b00101, 32'h00001234, 32'h44332211};
    vecs[4]  = '{32'h3410, 5'b01001, 32'h000003E0, 32'hFF00FF00};
    vecs[5]  = '{32'h3516, 5'b10111, 32'hABCD0000, 32'hFF0000AB};
    vecs[6]  = '{32'h3613, 5'b10011, 32'h5A000000, 32'hFF00005A};
    vecs[7]  = '{32'h3701, 5'b00000, 32'hCCBBAA99, 32'hFFCCBBAA};
    vecs[8]  = '{32'h3803, 5'b01111, 32'hF0A50000, 32'h55AA00FF};
    vecs[9]  = '{32'h3903, 5'b00111, 32'h87654321, 32'h87654321};
    vecs[10] = '{32'h3A00, 5'b00001, 32'h00008000, 32'hFF000084};
    for (int i = 0; i < 11; i++) begin
      do_fetch(vecs[i].addr, vecs[i].fmt, 8'(i), vecs[i].word, 32'h0, 0, 0, 1'b0);
      n_checks++; if (o_data !== vecs[i].exp || o_err !== 1'b0) $display("FAIL fmt%0d_data: got %h/%b want %h/0", i, o_data, o_err, vecs[i].exp); else n_pass++;
      n_checks++; if (o_nreq != 1 || o_addr[0] !== {vecs[i].addr[31:2], 2'b00}) $display("FAIL fmt%0d_mem: got %0d@%h want 1@%h", i, o_nreq, o_addr[0], {vecs[i].addr[31:2], 2'b00}); else n_pass++;
      n_checks++; if (o_tag !== 8'(i)) $display("FAIL fmt%0d_tag: got %h want %h", i, o_tag, 8'(i)); else n_pass++;
    end
  endtask

  task automatic test_compressed();
    do_fetch(32'h5000, 5'b00010, 8'hC3, 32'h0, 32'h0, 0, 5, 1'b0);
    n_checks++; if (o_nreq != 0) $display("FAIL etc2_nreq: got %0d want 0", o_nreq); else n_pass++;
    n_checks++; if (o_err !== 1'b1 || o_data !== 32'h0) $display("FAIL etc2_err_data: got %b/%h want 1/0", o_err, o_data); else n_pass++;
    n_checks++; if (o_tag !== 8'hC3) $display("FAIL etc2_tag: got %h want c3", o_tag); else n_pass++;
    n_checks++; if (o_tv_cyc != o_acc_cyc + 1) $display("FAIL etc2_tv_lat: got %0d want %0d", o_tv_cyc, o_acc_cyc + 1); else n_pass++;
    n_checks++; if (o_hold_ok !== 1'b1) $display("FAIL etc2_hold: got %b want 1", o_hold_ok); else n_pass++;
    n_checks++; if (o_idle_ok !== 1'b1) $display("FAIL etc2_back_idle: got %b want 1", o_idle_ok); else n_pass++;
    do_fetch(32'h5100, 5'b11111, 8'h3C, 32'h0, 32'h0, 0, 0, 1'b0);
    n_checks++; if (o_err !== 1'b1 || o_nreq != 0) $display("FAIL unknown_fmt: got %b/%0d want 1/0", o_err, o_nreq); else n_pass++;
  endtask

  task automatic test_stall();
    do_fetch(32'h1100, 5'b00100, 8'h77, 32'h0BADF00D, 32'h0, 3, 0, 1'b0);
    n_checks++; if (o_addr_stable !== 1'b1) $display("FAIL stall_addr_stable: got %b want 1", o_addr_stable); else n_pass++;
    n_checks++; if (o_nreq != 1 || o_addr[0] !== 32'h1100) $display("FAIL stall_mem: got %0d@%h want 1@00001100", o_nreq, o_addr[0]); else n_pass++;
    n_checks++; if (o_rsp_cyc != o_acc_cyc + 5) $display("FAIL stall_rsp_cyc: got %0d want %0d", o_rsp_cyc, o_acc_cyc + 5); else n_pass++;
    n_checks++; if (o_data !== 32'h0BADF00D) $display("FAIL stall_data: got %h want 0badf00d", o_data); else n_pass++;
  endtask

  task automatic test_reset_midop();
    logic seen;
    @(negedge clk);
    reqValid = 1'b1; reqAddr = 32'h9000; reqFormat = 5'b00100; reqTag = 8'h11;
    @(negedge clk);
    reqValid = 1'b0; memReqReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (memReqValid !== 1'b1 || memAddr !== 32'h9000) $display("FAIL midop_req_hold%0d: got %b@%h want 1@00009000", i, memReqValid, memAddr); else n_pass++;
      @(negedge clk);
    end
    memReqReady = 1'b1;
    @(negedge clk);
    memReqReady = 1'b0;
    n_checks++; if (memReqValid !== 1'b0) $display("FAIL midop_wait0: got %b want 0", memReqValid); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (reqReady !== 1'b0 || texValid !== 1'b0) $display("FAIL midop_in_reset: got %b/%b want 0/0", reqReady, texValid); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    memRspValid = 1'b1; memRspData = 32'hFFFFFFFF;
    @(negedge clk);
    memRspValid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (texValid || memReqValid) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL midop_late_rsp: got activity %b want 0", seen); else n_pass++;
    n_checks++; if (reqReady !== 1'b1) $display("FAIL midop_idle: got %b want 1", reqReady); else n_pass++;
  endtask

  task automatic test_cache();
    int exp_n;
    exp_n = CACHE_EN ? 0 : 1;
    do_fetch(32'h4000, 5'b00100, 8'h40, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
    n_checks++; if (o_nreq != 1 || o_data !== 32'hDEADBEEF) $display("FAIL cache_first: got %0d/%h want 1/deadbeef", o_nreq, o_data); else n_pass++;
    do_fetch(32'h4000, 5'b00100, 8'h41, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
    n_checks++; if (o_nreq != exp_n) $display("FAIL cache_second_nreq: got %0d want %0d", o_nreq, exp_n); else n_pass++;
    n_checks++; if (o_data !== 32'hDEADBEEF || o_tag !== 8'h41) $display("FAIL cache_second_data: got %h/%h want deadbeef/41", o_data, o_tag); else n_pass++;
    n_checks++; if (o_tv_cyc != (CACHE_EN ? o_acc_cyc + 1 : o_rsp_cyc + 1)) $display("FAIL cache_second_lat: got %0d acc %0d rsp %0d", o_tv_cyc, o_acc_cyc, o_rsp_cyc); else n_pass++;
    @(negedge clk); cacheInv = 1'b1;
    @(negedge clk); cacheInv = 1'b0;
    do_fetch(32'h4000, 5'b00100, 8'h42, 32'h12345678, 32'h0, 0, 0, 1'b0);
    n_checks++; if (o_nreq != 1 || o_data !== 32'h12345678) $display("FAIL cache_inv_refetch: got %0d/%h want 1/12345678", o_nreq, o_data); else n_pass++;
    do_fetch(32'h4000, 5'b00100, 8'h43, 32'hCAFEF00D, 32'h0, 0, 0, 1'b1);
    n_checks++; if (o_nreq != 1 || o_data !== 32'hCAFEF00D) $display("FAIL cache_inv_at_accept: got %0d/%h want 1/cafef00d", o_nreq, o_data); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; reqValid = 1'b0; reqAddr = '0; reqFormat = '0; reqTag = '0;
    memReqReady = 1'b0; memRspValid = 1'b0; memRspData = '0;
    cacheInv = 1'b0; texReady = 1'b0;
    test_reset();
    test_rgba32();
    test_rgb24_straddle();
    test_formats();
    test_compressed();
    test_stall();
    test_reset_midop();
    test_cache();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
